// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, oversampled majority-vote bit recovery,
// and a small byte FIFO with sticky frame-error and overrun flags.
module uart_rx #(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       bclk,
    input  logic       reset,
    input  logic       rx,
    input  logic       re,
    input  logic       clr_err,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       frame_err,
    output logic       overrun
);

    localparam int M  = OVERSAMPLE / 2;
    localparam int CW = $clog2(OVERSAMPLE);
    localparam int AW = $clog2(FIFO_DEPTH);

    // cnt holds the phase reached after each edge, so the edge that sees cnt=M
    // is the one where the phase advances to M+1: the decision edge.
    localparam logic [CW-1:0] C_S0   = CW'(M - 2);
    localparam logic [CW-1:0] C_S1   = CW'(M - 1);
    localparam logic [CW-1:0] C_DEC  = CW'(M);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_ONE  = CW'(1);
    localparam logic [AW:0]   P_ONE  = (AW + 1)'(1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t          state, state_next;
    logic            sync1, rx_s;
    logic [CW-1:0]   cnt, cnt_next;
    logic [2:0]      idx, idx_next;
    logic [7:0]      shreg, shreg_next;
    logic [1:0]      samp, samp_next;
    logic            maj;
    logic            push, fe_set, ovr_set;
    logic            fe_pend, ovr_pend;
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            full, pop, do_write;
    logic [7:0]      mem [FIFO_DEPTH];

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
        end
    end

    assign maj = (samp[0] & samp[1]) | (samp[0] & rx_s) | (samp[1] & rx_s);

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            samp  <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            idx   <= idx_next;
            shreg <= shreg_next;
            samp  <= samp_next;
        end
    end

    // NOTE: every output of this block gets a default first; a missed branch
    // would otherwise infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        shreg_next = shreg;
        samp_next  = samp;
        push       = 1'b0;
        fe_set     = 1'b0;

        if (state != IDLE && state != BRK) begin
            cnt_next = (cnt == C_LAST) ? '0 : cnt + C_ONE;
            if (cnt == C_S0) samp_next[0] = rx_s;
            if (cnt == C_S1) samp_next[1] = rx_s;
        end

        case (state)
            IDLE: begin
                cnt_next = '0;
                idx_next = '0;
                if (!rx_s) state_next = START;
            end
            START: begin
                if (cnt == C_DEC && maj) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == C_LAST) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (cnt == C_DEC) shreg_next = {maj, shreg[7:1]};
                if (cnt == C_LAST) begin
                    if (idx == 3'd7) state_next = STOP;
                    else             idx_next   = idx + 3'd1;
                end
            end
            STOP: begin
                if (cnt == C_DEC) begin
                    cnt_next = '0;
                    if (maj) begin
                        push       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        fe_set     = 1'b1;
                        state_next = BRK;
                    end
                end
            end
            BRK: begin
                cnt_next = '0;
                if (rx_s) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // FIFO: extra pointer MSB distinguishes full from empty.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rvalid   = (wr_ptr != rd_ptr);
    assign pop      = re && rvalid;
    assign do_write = push && (!full || pop);
    assign ovr_set  = push && full && !pop;
    assign rdata    = rvalid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + P_ONE;
            if (pop)      rd_ptr <= rd_ptr + P_ONE;
        end
    end

    // NOTE: storage is left unreset; rdata is gated by rvalid so stale
    // contents are never visible.
    always_ff @(posedge bclk) begin
        if (do_write) mem[wr_ptr[AW-1:0]] <= shreg;
    end

    // Flags rise one edge after the decision; a set wins over clr_err.
    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            fe_pend   <= 1'b0;
            ovr_pend  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            fe_pend  <= fe_set;
            ovr_pend <= ovr_set;
            if (fe_pend)      frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;
            if (ovr_pend)     overrun   <= 1'b1;
            else if (clr_err) overrun   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: table-driven frames plus hand-written corner
// sequences, with a byte scoreboard queue compared on every FIFO read.
module tb_uart_rx;

    localparam int OS = 16;

    logic       bclk;
    logic       reset;
    logic       rx;
    logic       re;
    logic       clr_err;
    logic [7:0] rdata;
    logic       rvalid;
    logic       frame_err;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        int         stops;
        logic [7:0] exp;
    } vec_t;

    uart_rx #(.OVERSAMPLE(OS), .FIFO_DEPTH(4)) dut (
        .bclk      (bclk),
        .reset     (reset),
        .rx        (rx),
        .re        (re),
        .clr_err   (clr_err),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    initial bclk = 1'b0;
    always #5 bclk = ~bclk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge bclk);
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (OS) @(negedge bclk);
    endtask

    task automatic send_frame(input logic [7:0] d, input int stops, input logic stop_val);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        for (int s = 0; s < stops; s++) drive_bit(stop_val);
        rx = 1'b1;
    endtask

    task automatic read_byte(input string name);
        logic [7:0] e;
        check({name, "_rvalid"}, rvalid, 1);
        if (exp_q.size() == 0) begin
            check({name, "_scoreboard_empty"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            check({name, "_rdata"}, rdata, e);
        end
        re = 1'b1;
        @(negedge bclk);
        re = 1'b0;
    endtask

    initial begin
        vec_t       vecs[5];
        int         n_edges;
        logic       seen;
        logic [7:0] partial;

        vecs[0] = '{8'h00, 1, 8'h00};
        vecs[1] = '{8'hFF, 1, 8'hFF};
        vecs[2] = '{8'h80, 1, 8'h80};
        vecs[3] = '{8'h01, 2, 8'h01};
        vecs[4] = '{8'h5A, 1, 8'h5A};

        reset = 1'b1; rx = 1'b1; re = 1'b0; clr_err = 1'b0;
        idle(3);
        check("reset_rvalid", rvalid, 0);
        check("reset_rdata", rdata, 8'h00);
        check("reset_frame_err", frame_err, 0);
        check("reset_overrun", overrun, 0);
        reset = 1'b0;
        idle(4);

        // 0xA5: latency from pin fall to rvalid
        fork
            send_frame(8'hA5, 1, 1'b1);
            begin
                n_edges = 0;
                while (n_edges < 300) begin
                    @(posedge bclk);
                    n_edges++;
                    #1;
                    if (rvalid) break;
                end
            end
        join
        exp_q.push_back(8'hA5);
        check("a5_latency_edges", n_edges, 156);
        check("a5_frame_err", frame_err, 0);
        check("a5_overrun", overrun, 0);
        read_byte("a5");
        check("a5_rvalid_after_pop", rvalid, 0);

        // Table of frames, one read each
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].stops, 1'b1);
            idle(OS);
            exp_q.push_back(vecs[i].exp);
            read_byte("table");
            check("table_rvalid_after_pop", rvalid, 0);
        end
        check("table_frame_err", frame_err, 0);

        // 3-cycle glitch, then a read strobe while empty
        rx = 1'b0; idle(3); rx = 1'b1;
        idle(4 * OS);
        check("glitch_rvalid", rvalid, 0);
        check("glitch_frame_err", frame_err, 0);
        re = 1'b1; idle(1); re = 1'b0;
        check("empty_re_rvalid", rvalid, 0);
        send_frame(8'hC3, 1, 1'b1);
        idle(OS);
        exp_q.push_back(8'hC3);
        read_byte("after_glitch");
        check("after_glitch_rvalid", rvalid, 0);

        // Bad stop bit followed by a 40-bit break
        send_frame(8'h3C, 1, 1'b0);
        rx = 1'b0;
        idle(40 * OS);
        check("break_frame_err", frame_err, 1);
        rx = 1'b1;
        idle(3 * OS);
        check("break_no_push", rvalid, 0);
        check("break_frame_err_sticky", frame_err, 1);
        clr_err = 1'b1; idle(1); clr_err = 1'b0;
        check("break_clr", frame_err, 0);
        send_frame(8'h11, 1, 1'b1);
        idle(OS);
        exp_q.push_back(8'h11);
        check("after_break_frame_err", frame_err, 0);
        read_byte("after_break");
        check("after_break_rvalid", rvalid, 0);

        // Flag set wins over a clr_err held high
        clr_err = 1'b1;
        seen = 1'b0;
        fork
            begin
                send_frame(8'h00, 1, 1'b0);
                idle(2 * OS);
            end
            begin
                repeat (12 * OS) begin
                    @(negedge bclk);
                    if (frame_err) seen = 1'b1;
                end
            end
        join
        clr_err = 1'b0;
        check("set_over_clr_seen", seen, 1);
        check("set_over_clr_final", frame_err, 0);
        check("set_over_clr_no_push", rvalid, 0);

        // Five back-to-back frames, 2 stop bits, no reads
        for (int b = 1; b <= 5; b++) begin
            send_frame(8'(b), 2, 1'b1);
            if (b <= 4) exp_q.push_back(8'(b));
        end
        idle(OS);
        check("overrun_set", overrun, 1);
        check("overrun_no_frame_err", frame_err, 0);
        for (int b = 1; b <= 4; b++) read_byte("overrun_read");
        check("overrun_drained", rvalid, 0);
        clr_err = 1'b1; idle(1); clr_err = 1'b0;
        check("overrun_clr", overrun, 0);

        // Full FIFO with a pop on the push edge of 0x55
        for (int b = 1; b <= 4; b++) begin
            send_frame(8'(b), 2, 1'b1);
            exp_q.push_back(8'(b));
        end
        fork
            send_frame(8'h55, 1, 1'b1);
            begin
                idle(155);
                check("full_pop_head", rdata, exp_q.pop_front());
                re = 1'b1;
                idle(1);
                re = 1'b0;
            end
        join
        exp_q.push_back(8'h55);
        idle(OS);
        check("full_pop_no_overrun", overrun, 0);
        for (int b = 0; b < 4; b++) read_byte("full_pop_read");
        check("full_pop_drained", rvalid, 0);

        // Reset at data bit 4 with a byte queued and frame_err set
        send_frame(8'h42, 1, 1'b1);
        send_frame(8'h00, 1, 1'b0);
        idle(2 * OS);
        check("pre_reset_rvalid", rvalid, 1);
        check("pre_reset_frame_err", frame_err, 1);
        partial = 8'h99;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(partial[i]);
        rx = partial[4];
        reset = 1'b1;
        idle(2);
        check("midreset_rvalid", rvalid, 0);
        check("midreset_rdata", rdata, 8'h00);
        check("midreset_frame_err", frame_err, 0);
        check("midreset_overrun", overrun, 0);
        rx = 1'b1;
        idle(10);
        reset = 1'b0;
        idle(2 * OS);
        check("post_reset_rvalid", rvalid, 0);
        send_frame(8'h7E, 1, 1'b1);
        idle(OS);
        exp_q.push_back(8'h7E);
        read_byte("post_reset");
        check("post_reset_drained", rvalid, 0);
        check("post_reset_frame_err", frame_err, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
